// File: rtl/audio_stream_pkg.sv
// Shared types and saturating helpers for the audio stream pipe.
package audio_stream_pkg;

  localparam int PIPE_LAT = 3;
  // Working width for saturating math; must cover DATA_W + 2^GAIN_W.
  localparam int WMAX     = 128;

  typedef enum logic [1:0] {RD_IDLE, RD_PULSE, RD_GAP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_PULSE, WR_GAP} wr_state_t;

  typedef logic signed [WMAX-1:0] wide_t;

  function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Arithmetic left shift in the wide domain, then saturate to [lo, hi].
  function automatic wide_t sat_shift(input wide_t x, input int sh, input wide_t lo, input wide_t hi);
    return clamp(x <<< sh, lo, hi);
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Frame FIFO: DEPTH entries of W bits, head always visible, occupancy count.
module audio_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             cnt_q;

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_ptr_q] <= data_i;

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/audio_stream_pipe.sv
// Codec-side audio streaming core: read FSM, 3-stage mute/gain/clip pipe,
// output frame FIFO and write FSM. Optional peak meter: AUDIO_STREAM_PEAK_EN.
module audio_stream_pipe
  import audio_stream_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int GAIN_W = 3
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       audio_in_available,
  input  logic                       audio_out_allowed,
  output logic                       read_audio_in,
  output logic                       write_audio_out,
  input  logic [NUM_CH*DATA_W-1:0]   audio_in,
  output logic [NUM_CH*DATA_W-1:0]   audio_out,
  input  logic                       mute_sw,
  input  logic [GAIN_W-1:0]          gain_sw,
  input  logic                       clip_sw,
  input  logic [DATA_W-2:0]          clip_lvl,
  input  logic                       peak_clr,
  output logic [DATA_W-2:0]          peak_level
);
  localparam int    CW   = $clog2(DEPTH) + 1;
  localparam wide_t SMAX = (wide_t'(1) <<< (DATA_W-1)) - wide_t'(1);
  localparam wide_t SMIN = -SMAX - wide_t'(1);

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef struct packed {
    logic              mute;
    logic [GAIN_W-1:0] gain;
    logic              clip;
  } cfg_t;

  logic                            rst_n;
  logic [1:0]                      rst_sync_q;
  cfg_t                            sw_meta_q, sw_sync_q, cfg1_q, cfg2_q;
  rd_state_t                       rd_state_q, rd_state_d;
  wr_state_t                       wr_state_q, wr_state_d;
  logic                            rd_pulse, rd_go, wr_pop;
  logic [PIPE_LAT:1]               vld_q;
  logic [PIPE_LAT:0]               vld_pipe;
  logic [NUM_CH-1:0][DATA_W-1:0]   s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
  logic [CW-1:0]                   fifo_cnt;
  logic [CW:0]                     occ;
  logic [NUM_CH*DATA_W-1:0]        fifo_head, audio_out_q;
  wide_t                           clip_hi, clip_lo;

  // Reset: assert asynchronously, release on a clock edge.
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  // Two-flop synchronisers for the asynchronous switches.
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= {mute_sw, gain_sw, clip_sw};
      sw_sync_q <= sw_meta_q;
    end

  // Occupancy counts frames already committed to the pipe so the FIFO never overflows.
  assign occ   = {1'b0, fifo_cnt} + (CW+1)'($countones(vld_q));
  assign rd_go = audio_in_available && (occ < (CW+1)'(DEPTH));

  // Read FSM next state: one strobe, then a guard cycle.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE:  if (rd_go) rd_state_d = RD_PULSE;
      RD_PULSE: rd_state_d = RD_GAP;
      RD_GAP:   rd_state_d = RD_IDLE;
      default:  rd_state_d = RD_IDLE;
    endcase
  end

  // Write FSM next state; pop happens on the IDLE->PULSE transition.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_pop     = 1'b0;
    case (wr_state_q)
      WR_IDLE: if ((fifo_cnt != '0) && audio_out_allowed) begin
        wr_state_d = WR_PULSE;
        wr_pop     = 1'b1;
      end
      WR_PULSE: wr_state_d = WR_GAP;
      WR_GAP:   wr_state_d = WR_IDLE;
      default:  wr_state_d = WR_IDLE;
    endcase
  end

  // State registers and the output frame register.
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      rd_state_q  <= RD_IDLE;
      wr_state_q  <= WR_IDLE;
      audio_out_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      if (wr_pop) audio_out_q <= fifo_head;
    end

  assign rd_pulse        = (rd_state_q == RD_PULSE);
  assign read_audio_in   = rd_pulse;
  assign write_audio_out = (wr_state_q == WR_PULSE);
  assign audio_out       = audio_out_q;
  assign vld_pipe        = {vld_q, rd_pulse};

  assign clip_hi = wide_t'({1'b0, clip_lvl});
  assign clip_lo = -clip_hi;

  // Per-channel stage datapaths; each frame carries the switch settings it entered with.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    samp_t s1_s, s2_s;
    assign s1_s    = s1_q[c];
    assign s2_s    = s2_q[c];
    assign s1_d[c] = sw_sync_q.mute ? '0 : audio_in[c*DATA_W +: DATA_W];
    assign s2_d[c] = DATA_W'(sat_shift(wide_t'(s1_s), int'(cfg1_q.gain), SMIN, SMAX));
    assign s3_d[c] = cfg2_q.clip ? DATA_W'(clamp(wide_t'(s2_s), clip_lo, clip_hi)) : s2_q[c];
  end

  // Pipeline registers advance only with their valid bit.
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      vld_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      cfg1_q <= '0;
      cfg2_q <= '0;
    end else begin
      vld_q <= vld_pipe[PIPE_LAT-1:0];
      if (vld_pipe[0]) begin
        s1_q   <= s1_d;
        cfg1_q <= sw_sync_q;
      end
      if (vld_pipe[1]) begin
        s2_q   <= s2_d;
        cfg2_q <= cfg1_q;
      end
      if (vld_pipe[2]) s3_q <= s3_d;
    end

  audio_frame_fifo #(.DEPTH(DEPTH), .W(NUM_CH*DATA_W)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (rst_n),
    .push_i  (vld_q[PIPE_LAT]),
    .data_i  (s3_q),
    .pop_i   (wr_pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

`ifdef AUDIO_STREAM_PEAK_EN
  logic [NUM_CH-1:0][DATA_W-2:0] mag;
  logic [DATA_W-2:0]             frame_max, peak_d, peak_q;

  // |x| per channel; the most negative value saturates to all-ones.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_mag
    logic [DATA_W-1:0] neg;
    assign neg    = -s3_q[c];
    assign mag[c] = s3_q[c][DATA_W-1] ? (neg[DATA_W-1] ? '1 : neg[DATA_W-2:0])
                                      : s3_q[c][DATA_W-2:0];
  end

  // Largest magnitude in the frame being pushed.
  always_comb begin
    frame_max = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (mag[c] > frame_max) frame_max = mag[c];
  end

  // Peak hold; clear wins over an update in the same cycle.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr)                                        peak_d = '0;
    else if (vld_q[PIPE_LAT] && (frame_max > peak_q))    peak_d = frame_max;
  end

  // Peak register.
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;

  assign peak_level = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_level      = '0;
`endif

endmodule

// File: tb/tb_audio_stream_pipe.sv
// Directed self-checking bench for audio_stream_pipe (default parameters).
module tb_audio_stream_pipe;
  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        audio_in_available, audio_out_allowed;
  logic        read_audio_in, write_audio_out;
  logic [63:0] audio_in, audio_out;
  logic        mute_sw, clip_sw, peak_clr;
  logic [2:0]  gain_sw;
  logic [30:0] clip_lvl, peak_level;

  int checks = 0;
  int errors = 0;

  audio_stream_pipe #(.NUM_CH(2), .DATA_W(32), .DEPTH(4), .GAIN_W(3)) dut (
    .CLOCK_50           (CLOCK_50),
    .resetn             (resetn),
    .audio_in_available (audio_in_available),
    .audio_out_allowed  (audio_out_allowed),
    .read_audio_in      (read_audio_in),
    .write_audio_out    (write_audio_out),
    .audio_in           (audio_in),
    .audio_out          (audio_out),
    .mute_sw            (mute_sw),
    .gain_sw            (gain_sw),
    .clip_sw            (clip_sw),
    .clip_lvl           (clip_lvl),
    .peak_clr           (peak_clr),
    .peak_level         (peak_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frm(input int k);
    return {32'(k + 100), 32'(k + 1)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // One frame through the design with the writer enabled; returns audio_out at the write strobe.
  task automatic run_frame(input logic [31:0] c0, input logic [31:0] c1, output logic [63:0] out);
    int n;
    audio_in = {c1, c0};
    audio_in_available = 1'b1;
    n = 0;
    while (read_audio_in !== 1'b1 && n < 60) begin step(1); n++; end
    check("rd_strobe_seen", {63'd0, read_audio_in}, 64'd1);
    step(1);
    audio_in_available = 1'b0;
    check("rd_strobe_width", {63'd0, read_audio_in}, 64'd0);
    n = 1;
    while (write_audio_out !== 1'b1 && n < 60) begin step(1); n++; end
    check("wr_strobe_seen", {63'd0, write_audio_out}, 64'd1);
    check("rd_to_wr_ge4", {63'd0, (n >= 4)}, 64'd1);
    out = audio_out;
    step(1);
    check("wr_strobe_width", {63'd0, write_audio_out}, 64'd0);
  endtask

  initial begin
    logic [63:0] o;
    int nrd, nwr;
    bit prev;

    resetn = 1'b0; audio_in_available = 1'b0; audio_out_allowed = 1'b0;
    audio_in = '0; mute_sw = 1'b0; gain_sw = 3'd0; clip_sw = 1'b0;
    clip_lvl = 31'd1000; peak_clr = 1'b0;
    step(3);
    check("rst_rd", {63'd0, read_audio_in}, 64'd0);
    check("rst_wr", {63'd0, write_audio_out}, 64'd0);
    check("rst_out", audio_out, 64'd0);
    check("rst_peak", {33'd0, peak_level}, 64'd0);
    resetn = 1'b1;
    audio_out_allowed = 1'b1;
    step(5);

    // 1: pass-through
    run_frame(32'h00001234, -32'sd5, o);
    check("t1_pass", o, {32'hFFFFFFFB, 32'h00001234});

    // mute
    mute_sw = 1'b1; step(4);
    run_frame(32'h00001234, -32'sd5, o);
    check("mute", o, 64'd0);
    mute_sw = 1'b0; step(4);

    // gain in range
    gain_sw = 3'd2; step(4);
    run_frame(32'd3, -32'sd3, o);
    check("gain2", o, {32'hFFFFFFF4, 32'h0000000C});

    // 2: gain saturation
    gain_sw = 3'd3; step(4);
    run_frame(32'h10000000, 32'hF0000000, o);
    check("t2_sat", o, {32'h80000000, 32'h7FFFFFFF});
    gain_sw = 3'd0;

    // 3: clip
    clip_sw = 1'b1; step(4);
    run_frame(32'd5000, -32'sd5000, o);
    check("t3_clip", o, {32'hFFFFFC18, 32'h000003E8});
    run_frame(32'd999, -32'sd999, o);
    check("t3_below", o, {32'hFFFFFC19, 32'h000003E7});
    clip_sw = 1'b0; step(4);

    // 4: backpressure fills FIFO, then drains in order
    audio_out_allowed = 1'b0; audio_in_available = 1'b1;
    audio_in = frm(0); nrd = 0; nwr = 0; prev = 1'b0;
    repeat (40) begin
      step(1);
      if (prev) begin audio_in = frm(nrd); prev = 1'b0; end
      if (read_audio_in) begin nrd++; prev = 1'b1; end
      if (write_audio_out) nwr++;
    end
    check("t4_reads", 64'(nrd), 64'd4);
    check("t4_no_wr", 64'(nwr), 64'd0);
    audio_in_available = 1'b0;
    step(1);
    audio_out_allowed = 1'b1;
    repeat (60) begin
      step(1);
      if (write_audio_out) begin check("t4_order", audio_out, frm(nwr)); nwr++; end
    end
    check("t4_writes", 64'(nwr), 64'd4);

    // 5: reset with two frames buffered
    audio_out_allowed = 1'b0; audio_in_available = 1'b1;
    audio_in = frm(10); nrd = 0; prev = 1'b0;
    repeat (30) begin
      if (nrd < 2) begin
        step(1);
        if (prev) begin audio_in = frm(10 + nrd); prev = 1'b0; end
        if (read_audio_in) begin nrd++; prev = 1'b1; if (nrd == 2) audio_in_available = 1'b0; end
      end
    end
    audio_in_available = 1'b0;
    check("t5_reads", 64'(nrd), 64'd2);
    step(8);
    #2 resetn = 1'b0;
    #1;
    check("t5_out0", audio_out, 64'd0);
    check("t5_rd0", {63'd0, read_audio_in}, 64'd0);
    check("t5_wr0", {63'd0, write_audio_out}, 64'd0);
    step(2);
    resetn = 1'b1;
    audio_out_allowed = 1'b1;
    nwr = 0;
    repeat (20) begin
      step(1);
      if (write_audio_out) nwr++;
    end
    check("t5_no_stale_wr", 64'(nwr), 64'd0);
    run_frame(32'h00000055, -32'sd2, o);
    check("t5_new_frame", o, {32'hFFFFFFFE, 32'h00000055});

`ifdef AUDIO_STREAM_PEAK_EN
    // 6: peak meter
    peak_clr = 1'b1; step(1); peak_clr = 1'b0;
    check("t6_clr0", {33'd0, peak_level}, 64'd0);
    run_frame(-32'sd7, 32'd0, o);
    check("t6_peak7", {33'd0, peak_level}, 64'd7);
    run_frame(32'd300, 32'd0, o);
    check("t6_peak300", {33'd0, peak_level}, 64'd300);
    run_frame(32'h80000000, 32'd0, o);
    check("t6_peakmin", {33'd0, peak_level}, 64'h7FFFFFFF);
    peak_clr = 1'b1; step(1); peak_clr = 1'b0;
    check("t6_clr", {33'd0, peak_level}, 64'd0);
`else
    check("peak_tied0", {33'd0, peak_level}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
